// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Optional ack watchdog is enabled with FETCH_TIMEOUT_EN.
package fetch_pkg;

  localparam int FETCH_WIDTH   = 16;
  localparam int FETCH_TIMEOUT = 15;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    VALID,
    DRAIN
  } fetch_state_e;

  localparam logic [FETCH_WIDTH-1:0] ADDR_RST  = '0;
  localparam logic [FETCH_WIDTH-1:0] INSTR_RST = '0;

endpackage

// File: rtl/fetch_timeout.sv
// Ack watchdog: counts consecutive busy cycles without a memory ack.
// Only instantiated when FETCH_TIMEOUT_EN is defined.
module fetch_timeout #(
  parameter int TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic busy_i,
  input  logic ack_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          wait_c;

  assign wait_c   = busy_i & ~ack_i;
  assign expire_o = wait_c & (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = '0;
    if (wait_c && !expire_o) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: req/ack fetch into an instruction register.
// Define FETCH_TIMEOUT_EN to add the sticky ack-timeout Fault.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int WIDTH   = FETCH_WIDTH,
  parameter int TIMEOUT = FETCH_TIMEOUT
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] PcValue,
  output logic             PcWrite,
  output logic [WIDTH-1:0] PcNext,
  input  logic             Redirect,
  input  logic [WIDTH-1:0] RedirectAddr,
  input  logic             Stall,
  output logic             MemReq,
  output logic [WIDTH-1:0] MemAddr,
  input  logic             MemAck,
  input  logic [WIDTH-1:0] MemData,
  output logic [WIDTH-1:0] Instr,
  output logic [WIDTH-1:0] InstrAddr,
  output logic             InstrValid,
  output logic             Fault
);

  fetch_state_e     state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] iaddr_q, iaddr_d;
  logic             ivalid_q, ivalid_d;
  logic             busy;
  logic             expire;
  logic             fault;

  assign busy = (state_q == REQ) | (state_q == DRAIN);

`ifdef FETCH_TIMEOUT_EN
  logic fault_q;

  fetch_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i    (CLK),
    .rst_ni   (Reset_n),
    .busy_i   (busy),
    .ack_i    (MemAck),
    .expire_o (expire)
  );

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n)    fault_q <= 1'b0;
    else if (expire) fault_q <= 1'b1;
  end

  assign fault = fault_q;
`else
  assign expire = 1'b0;
  assign fault  = 1'b0;
`endif

  // Redirect always wins the PC write port
  assign PcWrite = Reset_n & (Redirect | ((state_q == REQ) & MemAck));
  assign PcNext  = Redirect ? RedirectAddr : addr_q + WIDTH'(1);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    instr_d  = instr_q;
    iaddr_d  = iaddr_q;
    ivalid_d = ivalid_q;
    unique case (state_q)
      IDLE: begin
        if (!fault) begin
          state_d = REQ;
          addr_d  = Redirect ? RedirectAddr : PcValue;
        end
      end
      REQ: begin
        if (MemAck) begin
          if (Redirect) begin
            addr_d = RedirectAddr;
          end else begin
            instr_d  = MemData;
            iaddr_d  = addr_q;
            ivalid_d = 1'b1;
            state_d  = VALID;
          end
        end else if (Redirect) begin
          state_d = DRAIN;
        end
      end
      VALID: begin
        if (Redirect) begin
          ivalid_d = 1'b0;
          state_d  = REQ;
          addr_d   = RedirectAddr;
        end else if (!Stall) begin
          ivalid_d = 1'b0;
          state_d  = REQ;
          addr_d   = PcValue;
        end
      end
      DRAIN: begin
        // PC is not yet updated for a redirect in this same cycle
        if (MemAck) begin
          state_d = REQ;
          addr_d  = Redirect ? RedirectAddr : PcValue;
        end
      end
      default: state_d = IDLE;
    endcase
    if (expire) state_d = IDLE;
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      addr_q   <= WIDTH'(ADDR_RST);
      instr_q  <= WIDTH'(INSTR_RST);
      iaddr_q  <= WIDTH'(ADDR_RST);
      ivalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      instr_q  <= instr_d;
      iaddr_q  <= iaddr_d;
      ivalid_q <= ivalid_d;
    end
  end

  assign MemReq     = busy;
  assign MemAddr    = addr_q;
  assign Instr      = instr_q;
  assign InstrAddr  = iaddr_q;
  assign InstrValid = ivalid_q;
  assign Fault      = fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed-vector bench for fetch_unit with a behavioural Pc register.
// Build with FETCH_TIMEOUT_EN to exercise the watchdog path.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        Reset_n;
  logic [15:0] PcValue;
  logic        PcWrite;
  logic [15:0] PcNext;
  logic        Redirect;
  logic [15:0] RedirectAddr;
  logic        Stall;
  logic        MemReq;
  logic [15:0] MemAddr;
  logic        MemAck;
  logic [15:0] MemData;
  logic [15:0] Instr;
  logic [15:0] InstrAddr;
  logic        InstrValid;
  logic        Fault;

  logic        pc_load;
  logic [15:0] pc_load_val;
  logic [15:0] pc;

  int vectors     = 0;
  int miscompares = 0;

  fetch_unit dut (
    .CLK          (CLK),
    .Reset_n      (Reset_n),
    .PcValue      (PcValue),
    .PcWrite      (PcWrite),
    .PcNext       (PcNext),
    .Redirect     (Redirect),
    .RedirectAddr (RedirectAddr),
    .Stall        (Stall),
    .MemReq       (MemReq),
    .MemAddr      (MemAddr),
    .MemAck       (MemAck),
    .MemData      (MemData),
    .Instr        (Instr),
    .InstrAddr    (InstrAddr),
    .InstrValid   (InstrValid),
    .Fault        (Fault)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (pc_load)      pc <= pc_load_val;
    else if (PcWrite) pc <= PcNext;
  end

  assign PcValue = pc;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    Reset_n      = 1'b0;
    Redirect     = 1'b1;
    RedirectAddr = 16'h1234;
    Stall        = 1'b0;
    MemAck       = 1'b0;
    MemData      = 16'h0000;
    pc_load      = 1'b1;
    pc_load_val  = 16'h0050;
    tick();
    tick();
    chk("rst_memreq", 32'(MemReq), 32'h0);
    chk("rst_memaddr", 32'(MemAddr), 32'h0);
    chk("rst_instr", 32'(Instr), 32'h0);
    chk("rst_iaddr", 32'(InstrAddr), 32'h0);
    chk("rst_ivalid", 32'(InstrValid), 32'h0);
    chk("rst_fault", 32'(Fault), 32'h0);
    chk("rst_pcwrite", 32'(PcWrite), 32'h0);

    // release, enter REQ at 0x0050, then reset mid-handshake
    Redirect = 1'b0;
    pc_load  = 1'b0;
    Reset_n  = 1'b1;
    tick();
    chk("t1_req0", 32'(MemReq), 32'h1);
    chk("t1_addr0", 32'(MemAddr), 32'h0050);
    MemAck = 1'b1;
    #1;
    chk("t1_pcw0", 32'(PcWrite), 32'h1);
    Reset_n = 1'b0;
    #1;
    chk("t1_async_req", 32'(MemReq), 32'h0);
    chk("t1_async_addr", 32'(MemAddr), 32'h0);
    chk("t1_async_pcw", 32'(PcWrite), 32'h0);
    MemAck      = 1'b0;
    pc_load     = 1'b1;
    pc_load_val = 16'h0111;
    tick();
    pc_load = 1'b0;
    Reset_n = 1'b1;
    tick();
    chk("t1_req", 32'(MemReq), 32'h1);
    chk("t1_addr", 32'(MemAddr), 32'h0111);

    // zero-wait ack
    MemAck  = 1'b1;
    MemData = 16'hABCD;
    #1;
    chk("t2_pcw", 32'(PcWrite), 32'h1);
    chk("t2_pcnext", 32'(PcNext), 32'h0112);
    tick();
    MemAck = 1'b0;
    #1;
    chk("t2_ivalid", 32'(InstrValid), 32'h1);
    chk("t2_instr", 32'(Instr), 32'hABCD);
    chk("t2_iaddr", 32'(InstrAddr), 32'h0111);
    chk("t2_noreq", 32'(MemReq), 32'h0);
    tick();

    // three wait cycles, then ack and a 2-cycle stall
    for (int i = 0; i < 3; i++) begin
      chk("t3_wait_req", 32'(MemReq), 32'h1);
      chk("t3_wait_addr", 32'(MemAddr), 32'h0112);
      chk("t3_wait_pcw", 32'(PcWrite), 32'h0);
      tick();
    end
    MemAck  = 1'b1;
    MemData = 16'h1234;
    #1;
    chk("t3_pcnext", 32'(PcNext), 32'h0113);
    tick();
    MemAck = 1'b0;
    Stall  = 1'b1;
    #1;
    chk("t3_instr_a", 32'(Instr), 32'h1234);
    chk("t3_iaddr_a", 32'(InstrAddr), 32'h0112);
    tick();
    chk("t3_ivalid_b", 32'(InstrValid), 32'h1);
    chk("t3_instr_b", 32'(Instr), 32'h1234);
    chk("t3_noreq_b", 32'(MemReq), 32'h0);
    tick();
    Stall = 1'b0;
    #1;
    chk("t3_ivalid_c", 32'(InstrValid), 32'h1);
    tick();
    chk("t3_req", 32'(MemReq), 32'h1);
    chk("t3_addr", 32'(MemAddr), 32'h0113);
    chk("t3_ivalid_d", 32'(InstrValid), 32'h0);

    // redirect with ack to 0xFFFF, then wrap
    Redirect     = 1'b1;
    RedirectAddr = 16'hFFFF;
    MemAck       = 1'b1;
    MemData      = 16'hEEEE;
    #1;
    chk("t4_pcw_rd", 32'(PcWrite), 32'h1);
    chk("t4_pcnext_rd", 32'(PcNext), 32'hFFFF);
    tick();
    Redirect = 1'b0;
    MemAck   = 1'b0;
    #1;
    chk("t4_addr_ffff", 32'(MemAddr), 32'hFFFF);
    chk("t4_ivalid", 32'(InstrValid), 32'h0);
    MemAck  = 1'b1;
    MemData = 16'h5A5A;
    #1;
    chk("t4_pcnext_wrap", 32'(PcNext), 32'h0000);
    tick();
    MemAck = 1'b0;
    #1;
    chk("t4_instr", 32'(Instr), 32'h5A5A);
    chk("t4_iaddr", 32'(InstrAddr), 32'hFFFF);
    tick();
    chk("t4_addr_wrap", 32'(MemAddr), 32'h0000);

    // redirect while waiting -> DRAIN
    Redirect     = 1'b1;
    RedirectAddr = 16'h4321;
    #1;
    chk("t5_pcw", 32'(PcWrite), 32'h1);
    chk("t5_pcnext", 32'(PcNext), 32'h4321);
    tick();
    Redirect = 1'b0;
    #1;
    chk("t5_drain_req", 32'(MemReq), 32'h1);
    chk("t5_drain_addr", 32'(MemAddr), 32'h0000);
    chk("t5_drain_iv", 32'(InstrValid), 32'h0);
    tick();
    chk("t5_drain_req2", 32'(MemReq), 32'h1);
    MemAck  = 1'b1;
    MemData = 16'hDEAD;
    #1;
    chk("t5_drain_pcw", 32'(PcWrite), 32'h0);
    tick();
    MemAck = 1'b0;
    #1;
    chk("t5_addr", 32'(MemAddr), 32'h4321);
    chk("t5_iv", 32'(InstrValid), 32'h0);
    chk("t5_instr_kept", 32'(Instr), 32'h5A5A);

    // redirect together with ack in REQ
    Redirect     = 1'b1;
    RedirectAddr = 16'h0777;
    MemAck       = 1'b1;
    MemData      = 16'hBEEF;
    #1;
    chk("t5b_pcnext", 32'(PcNext), 32'h0777);
    tick();
    Redirect = 1'b0;
    MemAck   = 1'b0;
    #1;
    chk("t5b_addr", 32'(MemAddr), 32'h0777);
    chk("t5b_iv", 32'(InstrValid), 32'h0);
    chk("t5b_req", 32'(MemReq), 32'h1);

    // redirect in VALID overrides stall
    MemAck  = 1'b1;
    MemData = 16'h1111;
    tick();
    MemAck       = 1'b0;
    Stall        = 1'b1;
    Redirect     = 1'b1;
    RedirectAddr = 16'h0900;
    #1;
    chk("t5c_instr", 32'(Instr), 32'h1111);
    chk("t5c_pcnext", 32'(PcNext), 32'h0900);
    tick();
    Redirect = 1'b0;
    Stall    = 1'b0;
    #1;
    chk("t5c_addr", 32'(MemAddr), 32'h0900);
    chk("t5c_iv", 32'(InstrValid), 32'h0);

    // no ack: watchdog behaviour
`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 14; i++) tick();
    chk("t6_pre_fault", 32'(Fault), 32'h0);
    chk("t6_pre_req", 32'(MemReq), 32'h1);
    tick();
    chk("t6_fault", 32'(Fault), 32'h1);
    chk("t6_req_off", 32'(MemReq), 32'h0);
    MemAck = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_stuck_fault", 32'(Fault), 32'h1);
      chk("t6_stuck_req", 32'(MemReq), 32'h0);
    end
    MemAck  = 1'b0;
    Reset_n = 1'b0;
    #1;
    chk("t6_clear", 32'(Fault), 32'h0);
    Reset_n = 1'b1;
`else
    for (int i = 0; i < 20; i++) tick();
    chk("t6_req_held", 32'(MemReq), 32'h1);
    chk("t6_addr_held", 32'(MemAddr), 32'h0900);
    chk("t6_no_fault", 32'(Fault), 32'h0);
`endif
    tick();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
